// File: rtl/debounce_sync_pkg.sv
// Shared types for the debouncer: FSM state encoding and glitch counter sizing.
package debounce_sync_pkg;

  typedef enum logic [1:0] {
    DB_STABLE_LO = 2'd0,
    DB_WAIT_HI   = 2'd1,
    DB_STABLE_HI = 2'd2,
    DB_WAIT_LO   = 2'd3
  } db_state_e;

  localparam int GCNT_W = 8;

endpackage

// File: rtl/debounce_sync_sync_ff.sv
// Multi-flop synchronizer chain for a single asynchronous bit.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) chain_q <= {STAGES{RESET_VAL}};
    else       chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a bouncy level input; reports aborted qualifications as glitches.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 500000,
  parameter int   CNT_W       = 20,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_in,
  output logic              s_out,
  output logic              busy,
  output logic              glitch,
  output logic [GCNT_W-1:0] glitch_cnt,
  input  logic              glitch_clr
);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam db_state_e        RESET_STATE = RESET_LEVEL ? DB_STABLE_HI : DB_STABLE_LO;

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + GCNT_W'(1);
  endfunction

  logic              s_sync;
  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_out_q, s_out_d;
  logic              busy_q, busy_d;
  logic              glitch_q, glitch_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (s_in),
    .q_o   (s_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      s_out_q  <= RESET_LEVEL;
      busy_q   <= 1'b0;
      glitch_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_out_q  <= s_out_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
      gcnt_q   <= gcnt_d;
    end
  end

  // The counter holds the number of consecutive samples already seen at the candidate level.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      DB_STABLE_LO: if (s_sync) begin
        state_d = DB_WAIT_HI;
        cnt_d   = CNT_W'(1);
      end
      DB_WAIT_HI: begin
        if (!s_sync)                state_d = DB_STABLE_LO;
        else if (cnt_q == CNT_LAST) state_d = DB_STABLE_HI;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      DB_STABLE_HI: if (!s_sync) begin
        state_d = DB_WAIT_LO;
        cnt_d   = CNT_W'(1);
      end
      DB_WAIT_LO: begin
        if (s_sync)                 state_d = DB_STABLE_HI;
        else if (cnt_q == CNT_LAST) state_d = DB_STABLE_LO;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    s_out_d  = (state_d == DB_STABLE_HI) || (state_d == DB_WAIT_LO);
    busy_d   = (state_d == DB_WAIT_HI)   || (state_d == DB_WAIT_LO);
    glitch_d = ((state_q == DB_WAIT_HI) && (state_d == DB_STABLE_LO)) ||
               ((state_q == DB_WAIT_LO) && (state_d == DB_STABLE_HI));
    if (glitch_clr)    gcnt_d = '0;
    else if (glitch_d) gcnt_d = sat_inc(gcnt_q);
    else               gcnt_d = gcnt_q;
  end

  assign s_out      = s_out_q;
  assign busy       = busy_q;
  assign glitch     = glitch_q;
  assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomized bench for debounce_sync against a run-length reference model.
module tb_debounce_sync;

  localparam int SS = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset, s_in, glitch_clr, s_in1;
  logic       s_out, busy, glitch, s_out1, busy1, glitch1;
  logic [7:0] glitch_cnt, glitch_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: level, run length of disagreeing samples, glitch, count, input history.
  bit       m_out, m_glitch, m_busy;
  int       m_run;
  int       m_gcnt;
  bit       m_hist[$];
  bit       rl1_armed = 1'b0;

  debounce_sync #(.SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(3), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .s_in(s_in), .s_out(s_out), .busy(busy),
    .glitch(glitch), .glitch_cnt(glitch_cnt), .glitch_clr(glitch_clr)
  );

  debounce_sync #(.SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(3), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .s_in(s_in1), .s_out(s_out1), .busy(busy1),
    .glitch(glitch1), .glitch_cnt(glitch_cnt1), .glitch_clr(1'b0)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit din, input bit clr, input bit rst);
    bit seen;
    if (rst) begin
      m_out = 1'b0; m_run = 0; m_glitch = 1'b0; m_gcnt = 0;
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(din);
      m_glitch = 1'b0;
      if (seen != m_out) begin
        m_run = m_run + 1;
        if (m_run == DB) begin
          m_out = ~m_out;
          m_run = 0;
        end
      end else if (m_run > 0) begin
        m_glitch = 1'b1;
        m_run = 0;
      end
      if (clr)                            m_gcnt = 0;
      else if (m_glitch && m_gcnt < 255)  m_gcnt = m_gcnt + 1;
    end
    m_busy = (m_run > 0);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input bit din, input bit clr, input bit rst);
    @(negedge clk);
    s_in = din; glitch_clr = clr; reset = rst;
    @(posedge clk);
    model_step(din, clr, rst);
    if (rst) rl1_armed = 1'b1;
    #1;
    chk("s_out",      {7'd0, s_out},  {7'd0, m_out});
    chk("busy",       {7'd0, busy},   {7'd0, m_busy});
    chk("glitch",     {7'd0, glitch}, {7'd0, m_glitch});
    chk("glitch_cnt", glitch_cnt,     8'(m_gcnt));
    if (rl1_armed) begin
      chk("rl1_s_out", {7'd0, s_out1}, 8'd1);
      chk("rl1_busy",  {7'd0, busy1},  8'd0);
    end
  endtask

  initial begin
    int lvl, len;
    reset = 1'b1; s_in = 1'b0; glitch_clr = 1'b0; s_in1 = 1'b1;
    m_out = 1'b0; m_run = 0; m_glitch = 1'b0; m_gcnt = 0; m_busy = 1'b0;
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);

    tick(0, 0, 1);
    tick(0, 0, 1);

    // clean rise, then clean fall
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);

    // bounce on rise
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);

    // short pulse
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);

    // saturation of the glitch counter
    for (int n = 0; n < 300; n++) begin
      tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    end
    chk("gcnt_saturated", glitch_cnt, 8'd255);

    // clear coinciding with a glitch
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 1, 0);
    chk("glitch_on_clr", {7'd0, glitch}, 8'd1);
    chk("gcnt_cleared",  glitch_cnt,     8'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    // reset while qualifying a rise
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    tick(1, 0, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);

    // randomized level bursts with occasional clear and reset
    for (int n = 0; n < 1500; n++) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++)
        tick(bit'(lvl), ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
